// File: rtl/nou_cmd_arb.sv
// Round-robin arbiter that funnels NUM_REQ command FIFOs into one NOU request port
// and routes each in-order NOU response back to its requester through a tag FIFO.
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 64
`endif

module nou_cmd_arb #(
   parameter int NUM_REQ   = 4,
   parameter int CMD_WIDTH = `NOU_XOCC_CMD_WIDTH,
   parameter int MAX_OUTST = 8
) (
   input  logic                         nou_clk,
   input  logic                         nou_rst,
   input  logic [NUM_REQ-1:0]           req_cmd_empty,
   output logic [NUM_REQ-1:0]           req_cmd_rd_en,
   input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd_data,
   input  logic [NUM_REQ-1:0]           req_rsp_full,
   output logic [NUM_REQ-1:0]           req_rsp_wr_en,
   output logic [CMD_WIDTH-1:0]         req_rsp_data,
   output logic                         arb_nou_empty,
   input  logic                         nou_arb_rd_en,
   output logic [CMD_WIDTH-1:0]         arb_nou_data,
   output logic                         arb_rsp_full,
   input  logic                         nou_rsp_wr_en,
   input  logic [CMD_WIDTH-1:0]         nou_rsp_data,
   output logic                         rsp_orphan_err
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = $clog2(MAX_OUTST);

   typedef enum logic [1:0] {IDLE, FETCH, STAGED} state_t;

   state_t               state, state_nxt;
   logic [IW-1:0]        last_grant, win, cand;
   logic                 any_req, grant, pop, tag_empty, tag_full;
   logic [PW:0]          wr_ptr, rd_ptr;
   logic [IW-1:0]        tag_mem [MAX_OUTST];
   logic [IW-1:0]        head;
   logic [CMD_WIDTH-1:0] staging;

   // Walk downward so the closest index after last_grant is the last to assign win.
   always_comb begin
      win     = last_grant;
      cand    = last_grant;
      any_req = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NUM_REQ);
         if (!req_cmd_empty[cand]) begin
            win     = cand;
            any_req = 1'b1;
         end
      end
   end

   assign tag_empty = (wr_ptr == rd_ptr);
   assign tag_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head      = tag_mem[rd_ptr[PW-1:0]];
   assign grant     = (state == IDLE) && any_req && !tag_full;
   assign pop       = nou_rsp_wr_en && !tag_empty;

   always_comb begin
      state_nxt     = state;
      req_cmd_rd_en = '0;
      arb_nou_empty = 1'b1;
      case (state)
         IDLE: begin
            if (grant) begin
               req_cmd_rd_en[win] = 1'b1;
               state_nxt          = FETCH;
            end
         end
         FETCH:   state_nxt = STAGED;
         STAGED: begin
            arb_nou_empty = 1'b0;
            if (nou_arb_rd_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Response routing is purely combinational so NOU sees no extra write latency.
   always_comb begin
      req_rsp_wr_en = '0;
      if (pop) req_rsp_wr_en[head] = 1'b1;
   end

   assign req_rsp_data = nou_rsp_data;
   assign arb_rsp_full = tag_empty | req_rsp_full[head];
   assign arb_nou_data = staging;

   always_ff @(posedge nou_clk) begin
      if (nou_rst) begin
         state          <= IDLE;
         last_grant     <= IW'(NUM_REQ - 1);
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         staging        <= '0;
         rsp_orphan_err <= 1'b0;
         for (int i = 0; i < MAX_OUTST; i++) tag_mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            last_grant                <= win;
            tag_mem[wr_ptr[PW-1:0]]   <= win;
            wr_ptr                    <= wr_ptr + (PW+1)'(1);
         end
         // last_grant already names the FETCH requester.
         if (state == FETCH) staging <= req_cmd_data[int'(last_grant)*CMD_WIDTH +: CMD_WIDTH];
         if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
         if (nou_rsp_wr_en && tag_empty) rsp_orphan_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_nou_cmd_arb.sv
// Randomized bench for nou_cmd_arb: requester FIFOs, NOU and an in-order
// transaction model live here; every cycle is checked against that model.
module tb_nou_cmd_arb;
   localparam int NR = 4;
   localparam int CW = 16;
   localparam int MO = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_cmd_empty, req_cmd_rd_en, req_rsp_full, req_rsp_wr_en;
   logic [NR*CW-1:0] req_cmd_data;
   logic [CW-1:0]    req_rsp_data, arb_nou_data, nou_rsp_data;
   logic             arb_nou_empty, nou_arb_rd_en, arb_rsp_full, nou_rsp_wr_en, rsp_orphan_err;

   nou_cmd_arb #(.NUM_REQ(NR), .CMD_WIDTH(CW), .MAX_OUTST(MO)) dut (
      .nou_clk(clk), .nou_rst(rst),
      .req_cmd_empty(req_cmd_empty), .req_cmd_rd_en(req_cmd_rd_en), .req_cmd_data(req_cmd_data),
      .req_rsp_full(req_rsp_full), .req_rsp_wr_en(req_rsp_wr_en), .req_rsp_data(req_rsp_data),
      .arb_nou_empty(arb_nou_empty), .nou_arb_rd_en(nou_arb_rd_en), .arb_nou_data(arb_nou_data),
      .arb_rsp_full(arb_rsp_full), .nou_rsp_wr_en(nou_rsp_wr_en), .nou_rsp_data(nou_rsp_data),
      .rsp_orphan_err(rsp_orphan_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   // Model state: requester queues, last winner, in-flight command, tag order, NOU backlog.
   logic [CW-1:0] rq [NR][$];
   logic [CW-1:0] shown [NR];
   logic [CW-1:0] stg_cmd, nxt_val, last_rsp;
   logic [CW-1:0] pend [$];
   int            tagq [$];
   int            last, gcyc, cyc, g_win, n_gnt, n_rsp;
   bit            busy, chk_nxt, orphan_exp, g_fire;
   int            p_fill, p_pop, p_rsp, p_full;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] rsp_of(input logic [CW-1:0] c);
      return c ^ CW'(16'h00FF);
   endfunction

   task automatic step();
      int            win;
      bit            gnt, rd, staged, wr, exp_full;
      logic [NR-1:0] full_v, e_rd, e_wr;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if ($urandom_range(99) < p_fill && rq[i].size() < 4) rq[i].push_back(CW'($urandom));
         req_cmd_empty[i]          = (rq[i].size() == 0);
         req_cmd_data[i*CW +: CW]  = shown[i];
         full_v[i]                 = ($urandom_range(99) < p_full);
      end
      gnt = 0;
      win = last;
      if (!busy && tagq.size() < MO)
         for (int k = 1; k <= NR; k++)
            if (!gnt && rq[(last + k) % NR].size() != 0) begin
               gnt = 1;
               win = (last + k) % NR;
            end
      staged   = busy && (cyc >= gcyc + 2);
      rd       = staged ? ($urandom_range(99) < p_pop) : ($urandom_range(99) < 5);
      exp_full = (tagq.size() == 0) || full_v[tagq[0]];
      wr       = (pend.size() != 0) && !exp_full && ($urandom_range(99) < p_rsp);
      req_rsp_full  = full_v;
      nou_arb_rd_en = rd;
      nou_rsp_wr_en = wr;
      nou_rsp_data  = wr ? rsp_of(pend[0]) : CW'($urandom);
      #1;
      e_rd = '0;
      if (gnt) e_rd[win] = 1'b1;
      e_wr = '0;
      if (wr) e_wr[tagq[0]] = 1'b1;
      chk("cmd_rd_en", 32'(req_cmd_rd_en), 32'(e_rd));
      chk("nou_empty", 32'(arb_nou_empty), 32'(!staged));
      chk("rsp_full", 32'(arb_rsp_full), 32'(exp_full));
      chk("rsp_wr_en", 32'(req_rsp_wr_en), 32'(e_wr));
      chk("orphan", 32'(rsp_orphan_err), 32'(orphan_exp));
      if (wr) begin
         chk("rsp_data", 32'(req_rsp_data), 32'(rsp_of(pend[0])));
         last_rsp = req_rsp_data;
      end
      if (staged)  chk("nou_data", 32'(arb_nou_data), 32'(stg_cmd));
      if (chk_nxt) chk("nou_data_f1", 32'(arb_nou_data), 32'(nxt_val));
      chk_nxt = 0;
      g_fire  = gnt;
      if (gnt) begin
         stg_cmd    = rq[win].pop_front();
         shown[win] = stg_cmd;
         last       = win;
         g_win      = win;
         tagq.push_back(win);
         busy = 1;
         gcyc = cyc;
         n_gnt++;
      end
      if (rd && staged) begin
         busy    = 0;
         chk_nxt = 1;
         nxt_val = stg_cmd;
         pend.push_back(stg_cmd);
      end
      if (wr) begin
         void'(pend.pop_front());
         void'(tagq.pop_front());
         n_rsp++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      req_cmd_empty = '1;
      req_rsp_full  = '0;
      nou_arb_rd_en = 1'b0;
      nou_rsp_wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last = NR - 1;
      busy = 0; chk_nxt = 0; orphan_exp = 0;
      tagq.delete();
      pend.delete();
      for (int i = 0; i < NR; i++) rq[i].delete();
      #1;
      chk("rst_rd_en", 32'(req_cmd_rd_en), 0);
      chk("rst_wr_en", 32'(req_rsp_wr_en), 0);
      chk("rst_nou_empty", 32'(arb_nou_empty), 1);
      chk("rst_rsp_full", 32'(arb_rsp_full), 1);
      chk("rst_orphan", 32'(rsp_orphan_err), 0);
      chk("rst_staging", 32'(arb_nou_data), 0);
   endtask

   initial begin
      int got [$];
      rst = 1'b1;
      req_cmd_empty = '1; req_rsp_full = '0; req_cmd_data = '0;
      nou_arb_rd_en = 1'b0; nou_rsp_wr_en = 1'b0; nou_rsp_data = '0;
      for (int i = 0; i < NR; i++) shown[i] = '0;
      cyc = 0; gcyc = 0; n_gnt = 0; n_rsp = 0; g_win = 0; g_fire = 0;
      stg_cmd = '0; nxt_val = '0; last_rsp = '0;
      p_fill = 0; p_pop = 0; p_rsp = 0; p_full = 0;
      do_reset();

      // Orphan response with nothing outstanding; flag must stick.
      @(negedge clk);
      nou_rsp_wr_en = 1'b1;
      nou_rsp_data  = CW'(16'h1234);
      #1;
      chk("orphan_no_wr", 32'(req_rsp_wr_en), 0);
      @(negedge clk);
      nou_rsp_wr_en = 1'b0;
      #1;
      chk("orphan_set", 32'(rsp_orphan_err), 1);
      orphan_exp = 1;

      // Single requester round trip: 0xA5 in, 0x5A back.
      rq[0].push_back(CW'(16'h00A5));
      n_gnt = 0;
      repeat (4) step();
      chk("single_gnt_cnt", 32'(n_gnt), 1);
      p_pop = 100;
      step();
      step();
      chk("single_f1", 32'(arb_nou_data), 32'h00A5);
      p_rsp = 100; n_rsp = 0;
      step();
      step();
      chk("single_rsp_cnt", 32'(n_rsp), 1);
      chk("single_rsp_data", 32'(last_rsp), 32'h005A);
      chk("orphan_sticky", 32'(rsp_orphan_err), 1);

      // Fairness with every requester always non-empty.
      do_reset();
      p_fill = 100; p_pop = 100; p_rsp = 100; p_full = 0;
      for (int n = 0; n < 40 && got.size() < 6; n++) begin
         step();
         if (g_fire) got.push_back(g_win);
      end
      if (got.size() < 6) chk("fair_timeout", 32'(got.size()), 6);
      else for (int i = 0; i < 6; i++) chk("fair_order", 32'(got[i]), 32'(i % NR));

      // Outstanding limit: NOU never answers, then one answer frees one grant.
      do_reset();
      p_fill = 100; p_pop = 100; p_rsp = 0; n_gnt = 0;
      repeat (60) step();
      chk("outst_cap", 32'(n_gnt), MO);
      p_rsp = 100;
      step();
      p_rsp = 0; n_gnt = 0;
      repeat (20) step();
      chk("outst_release", 32'(n_gnt), 1);

      // Backpressure follows the head requester's full flag combinationally.
      do_reset();
      p_fill = 0; p_pop = 100; p_rsp = 0;
      rq[2].push_back(CW'(16'h0777));
      repeat (6) step();
      chk("bp_tags", 32'(tagq.size()), 1);
      @(negedge clk);
      nou_arb_rd_en = 1'b0; nou_rsp_wr_en = 1'b0;
      req_rsp_full = 4'b0100;
      #1;
      chk("bp_full", 32'(arb_rsp_full), 1);
      req_rsp_full = 4'b1011;
      #1;
      chk("bp_other_full", 32'(arb_rsp_full), 0);
      req_rsp_full = 4'b0000;
      #1;
      chk("bp_release", 32'(arb_rsp_full), 0);

      // Reset while STAGED with three tags outstanding.
      do_reset();
      p_fill = 100; p_pop = 100; p_rsp = 0;
      for (int n = 0; n < 40 && tagq.size() < 3; n++) step();
      chk("mid_tags", 32'(tagq.size()), 3);
      p_pop = 0;
      step();
      step();
      chk("mid_staged", 32'(arb_nou_empty), 0);
      do_reset();
      p_fill = 100; p_pop = 100;
      g_fire = 0;
      for (int n = 0; n < 5 && !g_fire; n++) step();
      if (!g_fire) chk("mid_gnt_timeout", 0, 1);
      else         chk("mid_next_win", 32'(g_win), 0);

      // Random soak.
      do_reset();
      p_fill = 40; p_pop = 60; p_rsp = 50; p_full = 30;
      repeat (3000) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/nou_cmd_arb.md
# nou_cmd_arb

Round-robin command arbiter that lets `NUM_REQ` DSA command/response FIFO pairs share a single NOU instance. Sits between the per-requester DSA command FIFOs and the NOU request-FIFO read port, presenting itself to NOU as one non-empty/read-enable FIFO. Every granted requester ID is recorded in an in-order tag FIFO, and each NOU response is written back to the response FIFO of the requester at the tag-FIFO head. NOU returns exactly one response per command, in command order.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `CMD_WIDTH`, `` `NOU_XOCC_CMD_WIDTH ``: command and response word width.
- `MAX_OUTST`, 8: tag-FIFO depth, i.e. the maximum number of granted commands without a response; power of two, ≥2.
- `nou_clk`  in  1  the only clock; all logic is on the rising edge.
- `nou_rst`  in  1  synchronous reset, active-high.
- `req_cmd_empty`  in  NUM_REQ  per-requester command FIFO empty.
- `req_cmd_rd_en`  out  NUM_REQ  one-hot pop to the requester command FIFOs.
- `req_cmd_data`  in  NUM_REQ*CMD_WIDTH  requester i's data is in slice i; it is valid the cycle after that requester's rd_en.
- `req_rsp_full`  in  NUM_REQ  per-requester response FIFO full.
- `req_rsp_wr_en`  out  NUM_REQ  one-hot response write.
- `req_rsp_data`  out  CMD_WIDTH  response word, shared by all requesters.
- `arb_nou_empty`  out  1  to NOU `req_fifo_nou_empty_f0`.
- `nou_arb_rd_en`  in  1  from NOU `nou_req_fifo_rd_en_f0`.
- `arb_nou_data`  out  CMD_WIDTH  to NOU `req_fifo_nou_data_f1`.
- `arb_rsp_full`  out  1  to NOU `rsp_fifo_nou_full`.
- `nou_rsp_wr_en`  in  1  from NOU `nou_rsp_fifo_wr_en`.
- `nou_rsp_data`  in  CMD_WIDTH  from NOU `nou_rsp_fifo_data`.
- `rsp_orphan_err`  out  1  sticky error flag: a response arrived while no command was outstanding.

## Operation
- Command FSM has three states: IDLE, FETCH, STAGED.
  - **IDLE:** grant when any `req_cmd_empty[i]==0` and the tag FIFO is not full. The winner is the first non-empty index searching upward from `last_grant+1`, modulo `NUM_REQ`. In the grant cycle: pulse `req_cmd_rd_en[win]`, push `win` into the tag FIFO, set `last_grant=win`, go to FETCH.
  - **FETCH:** capture `req_cmd_data[win]` into the staging register and go to STAGED.
  - **STAGED:** `arb_nou_empty=0`. On `nou_arb_rd_en`, go to IDLE.
- `arb_nou_empty=1` in every state except STAGED.
- The staging register holds its value until the next FETCH. `arb_nou_data` is the staging register, so the data is stable the cycle after `nou_arb_rd_en`, as the `_f1` contract requires.
- `nou_arb_rd_en` while `arb_nou_empty==1` is ignored: no state change.
- Response path:
  - `head` is the tag-FIFO head.
  - `arb_rsp_full = tag_empty | req_rsp_full[head]`.
  - On `nou_rsp_wr_en` with tag FIFO non-empty: `req_rsp_wr_en[head]=1` combinationally in the same cycle, `req_rsp_data=nou_rsp_data`, pop the tag FIFO.
  - On `nou_rsp_wr_en` with tag FIFO empty: drop the response, no write, set `rsp_orphan_err`. The flag is cleared only by reset.
- Tag-FIFO push (IDLE grant) and pop (response) in the same cycle are both performed; the count is unchanged.
- The tag FIFO uses `log2(MAX_OUTST)+1`-bit pointers, and wrap-around is handled by the MSB compare. Full means `count==MAX_OUTST`, and no grant happens while full.
- `last_grant` resets to `NUM_REQ-1`, so the first search starts at index 0.

## Timing
- Reset values:
  - FSM=IDLE, tag FIFO empty, `last_grant=NUM_REQ-1`, staging=0.
  - `arb_nou_empty=1`, `arb_rsp_full=1` (tag empty), `rsp_orphan_err=0`.
  - `req_cmd_rd_en=0`, `req_rsp_wr_en=0`.
- Reset asserted mid-operation discards the staged command and all outstanding tags. Recovering requesters after that is the system's responsibility.
- Command latency: grant at cycle t, `arb_nou_empty` falls at t+2. If NOU pops at t+2, the next grant can be at t+3. Peak throughput is one command per 3 cycles.
- Response path is zero-latency combinational from `nou_rsp_wr_en` to `req_rsp_wr_en`. `arb_rsp_full` is combinational from the registered tag head and `req_rsp_full`.

## Test plan
- **Single requester:** req0 holds one command 0xA5 → `req_cmd_rd_en[0]` pulses once, `arb_nou_empty` falls 2 cycles later. NOU pops, sees 0xA5 the next cycle, answers 0x5A → `req_rsp_wr_en=4'b0001` with data 0x5A.
- **Fairness:** all 4 requesters continuously non-empty → grant order 0,1,2,3,0,1 and responses are routed in the same order.
- **Outstanding limit:** `MAX_OUTST=8`, NOU pops but never responds → exactly 8 grants, then `req_cmd_rd_en` stays 0. One response releases exactly one more grant.
- **Response backpressure:** head tag=2 with `req_rsp_full[2]=1` → `arb_rsp_full=1`. Deasserting `req_rsp_full[2]` drops `arb_rsp_full` in the same cycle.
- **Orphan response:** `nou_rsp_wr_en` after reset with nothing outstanding → no `req_rsp_wr_en`, `rsp_orphan_err=1` until reset.
- **Mid-operation reset:** assert `nou_rst` in STAGED with 3 tags outstanding → next cycle `arb_nou_empty=1`, `arb_rsp_full=1`, and the next grant goes to index 0.
